aes_ahb_master: RTL and testbench
=================================

AES_AHB_MASTER -- requirements
Module: aes_ahb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AHB address width.
REQ-002 SHALL have port clk, input, 1: system clock; all logic is rising-edge.
REQ-003 SHALL have port n_rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port ahb_shift_en, input, 1: one-cycle block-transfer request from the AES controller.
REQ-005 SHALL have port ahb_mode, input, 1: direction for that request; 0 = read from SRAM, 1 = write to SRAM.
REQ-006 SHALL have port cfg_load, input, 1: loads the three base/count values below.
REQ-007 SHALL have ports src_base and dst_base, input, ADDR_W each: source and destination byte addresses.
REQ-008 SHALL have port num_blocks, input, 16: number of 128-bit blocks in the job.
REQ-009 SHALL have port tx_block, input, 128: ciphertext block to write.
REQ-010 SHALL have ports HADDR (output, ADDR_W), HTRANS (output, 2), HWRITE (output, 1), HSIZE (output, 3), HBURST (output, 3), HWDATA (output, 32): AHB-Lite master outputs.
REQ-011 SHALL have ports HRDATA (input, 32), HREADY (input, 1), HRESP (input, 1): AHB-Lite master inputs.
REQ-012 SHALL have ports rx_block (output, 128) and rx_valid (output, 1): block read from SRAM, and a one-cycle valid pulse for it.
REQ-013 SHALL have ports blk_done (output, 1), busy (output, 1), last_round (output, 1), err_flag (output, 1).

Function
REQ-014 Each block transfer SHALL be one INCR4 burst: HBURST=3'b011, HSIZE=3'b010; beat 0 NONSEQ, beats 1-3 SEQ; HADDR=ptr+4*k.
REQ-015 States SHALL be IDLE, ADDR0, BURST, LAST_DATA, ERR.
REQ-016 IDLE + ahb_shift_en SHALL latch ahb_mode, go to ADDR0, and assert busy from the next cycle.
REQ-017 ADDR0 SHALL drive beat-0 address with HWRITE=mode, and advance to BURST when HREADY=1.
REQ-018 BURST SHALL issue address k+1 while beat k is in its data phase, advancing only on HREADY=1.
REQ-019 BURST SHALL go to LAST_DATA after beat 3's address is accepted.
REQ-020 LAST_DATA SHALL drive HTRANS=IDLE and return to IDLE when HREADY=1.
REQ-021 HREADY=0 SHALL freeze HADDR, HTRANS, HWDATA and the beat counter.
REQ-022 Write data SHALL be presented in the data phase of beat k as HWDATA=tx_block[127-32k -: 32]; tx_block SHALL be sampled once, at request acceptance.
REQ-023 Reads SHALL capture HRDATA into rx_block word k on HREADY=1 in the data phase of beat k.
REQ-024 On completion of the final data phase, the next cycle SHALL pulse blk_done, plus rx_valid when reading; busy SHALL deassert in that same cycle.
REQ-025 Request-to-blk_done latency SHALL be 6 cycles with zero wait states.
REQ-026 The read pointer (from src_base) and write pointer (from dst_base) SHALL each advance by 16 after every completed block in their direction.
REQ-027 Bits [3:0] of both base addresses SHALL be forced to 0, so a burst never crosses a 1KB boundary.
REQ-028 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-029 last_round SHALL be a combinational level equal to (wr_count == num_blocks-1), where wr_count counts completed writes.
REQ-030 num_blocks=0 SHALL be treated as 1.
REQ-031 cfg_load in IDLE SHALL load src_base, dst_base and num_blocks, clear both counters and clear err_flag.
REQ-032 cfg_load while busy SHALL be ignored.
REQ-033 ahb_shift_en while busy SHALL be ignored, with no queueing.
REQ-034 If ahb_shift_en and cfg_load are both asserted in IDLE, cfg_load SHALL be applied first and the transfer SHALL use the new values.
REQ-035 HRESP=1 with HREADY=0 SHALL drive HTRANS=IDLE in the next cycle and enter ERR.
REQ-036 ERR SHALL set err_flag (sticky), produce no blk_done, leave pointers unchanged, and return to IDLE one cycle later.

Reset
REQ-037 On n_rst=0 the block SHALL enter IDLE asynchronously.
REQ-038 Reset SHALL force HTRANS=0, HADDR=0, HWRITE=0, HWDATA=0, HBURST=3'b011, HSIZE=3'b010, rx_block=0, rx_valid=0, blk_done=0, busy=0, err_flag=0, both pointers=0, both counters=0 and num_blocks register=1.
REQ-039 Reset mid-burst SHALL abandon the burst with no completion pulse.

Verification
REQ-040 cfg_load src=0x100, dst=0x200, n=2; read request; slave returns 0xA,0xB,0xC,0xD -> HADDR 0x100,0x104,0x108,0x10C; rx_block=0x0000000A_0000000B_0000000C_0000000D; rx_valid at cycle 6.
REQ-041 Write request with tx_block=0x11..11_22..22_33..33_44..44 -> HWDATA sequence 0x11111111, 0x22222222, 0x33333333, 0x44444444 at 0x200-0x20C; last_round=0 before, next write at 0x210 shows last_round=1.
REQ-042 HREADY held low for 2 cycles during beat 2 -> HADDR/HWDATA frozen; blk_done at cycle 8.
REQ-043 HRESP ERROR on beat 1 -> HTRANS=IDLE next cycle; err_flag=1; no blk_done; the next read restarts at the same address; cfg_load clears err_flag.
REQ-044 ahb_shift_en pulsed while busy, and n_rst asserted mid-burst -> second request ignored; after reset all outputs match REQ-038.

Source files
------------

// File: rtl/aes_ahb_master.sv
// AHB-Lite master moving 128-bit AES blocks to/from SRAM as single INCR4 bursts.
// Read and write pointers advance independently; errors abort the burst and set a sticky flag.
module aes_ahb_master #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              ahb_shift_en,
  input  logic              ahb_mode,
  input  logic              cfg_load,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [15:0]       num_blocks,
  input  logic [127:0]      tx_block,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic [127:0]      rx_block,
  output logic              rx_valid,
  output logic              blk_done,
  output logic              busy,
  output logic              last_round,
  output logic              err_flag
);

  localparam logic [1:0]  HT_IDLE   = 2'b00;
  localparam logic [1:0]  HT_NONSEQ = 2'b10;
  localparam logic [1:0]  HT_SEQ    = 2'b11;
  localparam int unsigned BLK_BYTES = 16;

  typedef enum logic [2:0] {IDLE, ADDR0, BURST, LAST_DATA, ERR} state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [127:0]        tx_q, tx_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [1:0]          beat_q, beat_d;
  logic [ADDR_W-1:0]   haddr_q, haddr_d;
  logic [1:0]          htrans_q, htrans_d;
  logic                hwrite_q, hwrite_d;
  logic [31:0]         hwdata_q, hwdata_d;
  logic [127:0]        rx_q, rx_d;
  logic                rx_valid_q, rx_valid_d;
  logic                blk_done_q, blk_done_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [15:0]         wr_cnt_q, wr_cnt_d;
  logic [15:0]         nblk_q, nblk_d;
  logic [ADDR_W-1:0]   src_al, dst_al;

  // Word k of a block sits in the most-significant-first 32-bit lane k.
  function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] k);
    case (k)
      2'd0:    word_of = blk[127:96];
      2'd1:    word_of = blk[95:64];
      2'd2:    word_of = blk[63:32];
      default: word_of = blk[31:0];
    endcase
  endfunction

  function automatic logic [127:0] put_word(input logic [127:0] blk, input logic [1:0] k,
                                            input logic [31:0] w);
    put_word = blk;
    case (k)
      2'd0:    put_word[127:96] = w;
      2'd1:    put_word[95:64]  = w;
      2'd2:    put_word[63:32]  = w;
      default: put_word[31:0]   = w;
    endcase
  endfunction

  assign src_al = {src_base[ADDR_W-1:4], 4'b0000};
  assign dst_al = {dst_base[ADDR_W-1:4], 4'b0000};

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tx_d       = tx_q;
    base_d     = base_q;
    beat_d     = beat_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hwdata_d   = hwdata_q;
    rx_d       = rx_q;
    rx_valid_d = 1'b0;
    blk_done_d = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    wr_cnt_d   = wr_cnt_q;
    nblk_d     = nblk_q;

    case (state_q)
      IDLE: begin
        if (cfg_load) begin
          rd_ptr_d = src_al;
          wr_ptr_d = dst_al;
          nblk_d   = (num_blocks == 16'd0) ? 16'd1 : num_blocks;
          wr_cnt_d = 16'd0;
          err_d    = 1'b0;
        end
        if (ahb_shift_en) begin
          // A same-cycle cfg_load supplies the burst base directly.
          if (ahb_mode) base_d = cfg_load ? dst_al : wr_ptr_q;
          else          base_d = cfg_load ? src_al : rd_ptr_q;
          mode_d   = ahb_mode;
          tx_d     = tx_block;
          haddr_d  = base_d;
          htrans_d = HT_NONSEQ;
          hwrite_d = ahb_mode;
          beat_d   = 2'd0;
          busy_d   = 1'b1;
          state_d  = ADDR0;
        end
      end
      ADDR0: begin
        if (HREADY) begin
          hwdata_d = word_of(tx_q, 2'd0);
          haddr_d  = base_q + ADDR_W'(4);
          htrans_d = HT_SEQ;
          beat_d   = 2'd1;
          state_d  = BURST;
        end
      end
      BURST: begin
        if (HREADY) begin
          if (!mode_q) rx_d = put_word(rx_q, 2'(beat_q - 2'd1), HRDATA);
          hwdata_d = word_of(tx_q, beat_q);
          if (beat_q == 2'd3) begin
            htrans_d = HT_IDLE;
            state_d  = LAST_DATA;
          end else begin
            haddr_d = base_q + ADDR_W'({2'(beat_q + 2'd1), 2'b00});
            beat_d  = 2'(beat_q + 2'd1);
          end
        end else if (HRESP) begin
          htrans_d = HT_IDLE;
          err_d    = 1'b1;
          state_d  = ERR;
        end
      end
      LAST_DATA: begin
        if (HREADY) begin
          if (!mode_q) begin
            rx_d     = put_word(rx_q, 2'd3, HRDATA);
            rd_ptr_d = rd_ptr_q + ADDR_W'(BLK_BYTES);
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(BLK_BYTES);
            wr_cnt_d = wr_cnt_q + 16'd1;
          end
          blk_done_d = 1'b1;
          rx_valid_d = !mode_q;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else if (HRESP) begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      ERR: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      tx_q       <= '0;
      base_q     <= '0;
      beat_q     <= 2'd0;
      haddr_q    <= '0;
      htrans_q   <= HT_IDLE;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      rx_q       <= '0;
      rx_valid_q <= 1'b0;
      blk_done_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      wr_cnt_q   <= 16'd0;
      nblk_q     <= 16'd1;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tx_q       <= tx_d;
      base_q     <= base_d;
      beat_q     <= beat_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      rx_q       <= rx_d;
      rx_valid_q <= rx_valid_d;
      blk_done_q <= blk_done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_cnt_q   <= wr_cnt_d;
      nblk_q     <= nblk_d;
    end
  end

  assign HADDR      = haddr_q;
  assign HTRANS     = htrans_q;
  assign HWRITE     = hwrite_q;
  assign HWDATA     = hwdata_q;
  assign HSIZE      = 3'b010;
  assign HBURST     = 3'b011;
  assign rx_block   = rx_q;
  assign rx_valid   = rx_valid_q;
  assign blk_done   = blk_done_q;
  assign busy       = busy_q;
  assign err_flag   = err_q;
  assign last_round = (wr_cnt_q == 16'(nblk_q - 16'd1));

endmodule

// File: tb/tb_aes_ahb_master.sv
// Directed plus randomized bench for aes_ahb_master with an AHB slave and a
// job-level model of pointers, counters and expected burst contents.
module tb_aes_ahb_master;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              n_rst = 1'b1;
  logic              ahb_shift_en = 1'b0, ahb_mode = 1'b0, cfg_load = 1'b0;
  logic [ADDR_W-1:0] src_base = '0, dst_base = '0;
  logic [15:0]       num_blocks = '0;
  logic [127:0]      tx_block = '0;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE, HBURST;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA = '0;
  logic              HREADY = 1'b1, HRESP = 1'b0;
  logic [127:0]      rx_block;
  logic              rx_valid, blk_done, busy, last_round, err_flag;

  aes_ahb_master #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .n_rst(n_rst), .ahb_shift_en(ahb_shift_en), .ahb_mode(ahb_mode),
    .cfg_load(cfg_load), .src_base(src_base), .dst_base(dst_base), .num_blocks(num_blocks),
    .tx_block(tx_block), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .rx_block(rx_block), .rx_valid(rx_valid), .blk_done(blk_done), .busy(busy),
    .last_round(last_round), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Job-level reference state
  logic [31:0] m_rd_ptr = '0, m_wr_ptr = '0;
  logic [15:0] m_wr_cnt = '0, m_nblk = 16'd1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wrd(input logic [127:0] b, input int k);
    return b[127-32*k -: 32];
  endfunction

  function automatic logic exp_last();
    return m_wr_cnt == 16'(m_nblk - 16'd1);
  endfunction

  task automatic model_cfg(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    m_rd_ptr = s & 32'hFFFF_FFF0;
    m_wr_ptr = d & 32'hFFFF_FFF0;
    m_nblk   = (n == 16'd0) ? 16'd1 : n;
    m_wr_cnt = 16'd0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "/htrans"}, 128'(HTRANS), 128'(0));
    chk({tag, "/haddr"}, 128'(HADDR), 128'(0));
    chk({tag, "/hwrite"}, 128'(HWRITE), 128'(0));
    chk({tag, "/hwdata"}, 128'(HWDATA), 128'(0));
    chk({tag, "/hburst"}, 128'(HBURST), 128'(3'b011));
    chk({tag, "/hsize"}, 128'(HSIZE), 128'(3'b010));
    chk({tag, "/rx_block"}, rx_block, 128'(0));
    chk({tag, "/flags"}, 128'({rx_valid, blk_done, busy, err_flag}), 128'(0));
    chk({tag, "/last_round"}, 128'(last_round), 128'(1));
  endtask

  task automatic cfg(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    cfg_load = 1'b1; src_base = s; dst_base = d; num_blocks = n;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    model_cfg(s, d, n);
    chk("cfg/err_flag", 128'(err_flag), 128'(0));
    chk("cfg/last_round", 128'(last_round), 128'(exp_last()));
  endtask

  // One block transfer with a slave stalling beat wbeat's data phase for wlen cycles.
  task automatic xfer(input string tag, input logic mode, input logic [127:0] tx,
                      input logic [127:0] rdw, input int wbeat, input int wlen,
                      input logic do_cfg, input logic [31:0] c_src, input logic [31:0] c_dst,
                      input logic [15:0] c_n, input logic poke);
    logic [31:0] base;
    int beat_a, dp, dpw, done;
    logic hr;
    chk({tag, "/last_round_pre"}, 128'(last_round), 128'(exp_last()));
    ahb_shift_en = 1'b1; ahb_mode = mode; tx_block = tx; HREADY = 1'b1; HRESP = 1'b0;
    if (do_cfg) begin
      cfg_load = 1'b1; src_base = c_src; dst_base = c_dst; num_blocks = c_n;
      model_cfg(c_src, c_dst, c_n);
    end
    base = mode ? m_wr_ptr : m_rd_ptr;
    @(posedge clk); #1;
    ahb_shift_en = 1'b0; cfg_load = 1'b0;
    tx_block = {$urandom, $urandom, $urandom, $urandom};
    beat_a = 0; dp = -1; dpw = 0; done = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (blk_done) begin done = cyc; break; end
      chk({tag, "/busy"}, 128'(busy), 128'(1));
      if (poke && cyc == 2) begin
        ahb_shift_en = 1'b1; ahb_mode = ~mode; cfg_load = 1'b1;
        src_base = $urandom; dst_base = $urandom; num_blocks = 16'($urandom);
      end else begin
        ahb_shift_en = 1'b0; cfg_load = 1'b0;
      end
      hr = 1'b1;
      if (dp >= 0 && dp == wbeat && dpw < wlen) hr = 1'b0;
      if (beat_a < 4) begin
        chk({tag, "/htrans"}, 128'(HTRANS), 128'((beat_a == 0) ? 2'b10 : 2'b11));
        chk({tag, "/haddr"}, 128'(HADDR), 128'(base + 32'(4 * beat_a)));
        chk({tag, "/hwrite"}, 128'(HWRITE), 128'(mode));
        chk({tag, "/hburst_hsize"}, 128'({HBURST, HSIZE}), 128'(6'b011_010));
      end else begin
        chk({tag, "/htrans_idle"}, 128'(HTRANS), 128'(0));
      end
      if (dp >= 0) begin
        if (mode) chk({tag, "/hwdata"}, 128'(HWDATA), 128'(wrd(tx, dp)));
        else HRDATA = wrd(rdw, dp);
      end
      HREADY = hr;
      if (hr) begin
        dp = (beat_a < 4) ? beat_a : -1;
        if (beat_a < 4) beat_a++;
        dpw = 0;
      end else begin
        dpw++;
      end
      @(posedge clk); #1;
    end
    ahb_shift_en = 1'b0; cfg_load = 1'b0; HREADY = 1'b1;
    chk({tag, "/latency"}, 128'(done), 128'(6 + ((wbeat < 4) ? wlen : 0)));
    if (done != 0) begin
      chk({tag, "/busy_done"}, 128'(busy), 128'(0));
      chk({tag, "/rx_valid"}, 128'(rx_valid), 128'(!mode));
      if (!mode) chk({tag, "/rx_block"}, rx_block, rdw);
      if (mode) begin m_wr_ptr += 32'd16; m_wr_cnt++; end
      else m_rd_ptr += 32'd16;
      @(posedge clk); #1;
      chk({tag, "/pulse_end"}, 128'({blk_done, rx_valid}), 128'(0));
      chk({tag, "/last_round_post"}, 128'(last_round), 128'(exp_last()));
    end
  endtask

  initial begin
    logic [127:0] rnd_tx, rnd_rd;
    logic rmode, rcfg;
    #2 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset("por");
    @(posedge clk); #1 n_rst = 1'b1;

    // Basic read then writes
    cfg(32'h100, 32'h200, 16'd2);
    xfer("rd0", 1'b0, '0, {32'hA, 32'hB, 32'hC, 32'hD}, 4, 0, 1'b0, '0, '0, '0, 1'b0);
    xfer("wr0", 1'b1, {{4{8'h11}}, {4{8'h22}}, {4{8'h33}}, {4{8'h44}}}, '0, 4, 0,
         1'b0, '0, '0, '0, 1'b0);
    xfer("wr1_wait", 1'b1, {$urandom, $urandom, $urandom, $urandom}, '0, 2, 2,
         1'b0, '0, '0, '0, 1'b0);

    // Error on beat 1 of a read at 0x110
    ahb_shift_en = 1'b1; ahb_mode = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    @(posedge clk); #1 ahb_shift_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 HRESP = 1'b1; HREADY = 1'b0;
    @(posedge clk); #1;
    chk("err/htrans", 128'(HTRANS), 128'(0));
    chk("err/err_flag", 128'(err_flag), 128'(1));
    HREADY = 1'b1;
    @(posedge clk); #1 HRESP = 1'b0;
    chk("err/busy", 128'(busy), 128'(0));
    for (int i = 0; i < 4; i++) begin
      chk("err/no_done", 128'(blk_done), 128'(0));
      @(posedge clk); #1;
    end
    chk("err/sticky", 128'(err_flag), 128'(1));

    // Retry at the same address while poking requests/config mid-burst
    xfer("rd_retry", 1'b0, '0, {$urandom, $urandom, $urandom, $urandom}, 4, 0,
         1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("poke/no_extra", 128'({HTRANS, blk_done, busy}), 128'(0));
      @(posedge clk); #1;
    end
    chk("poke/err_kept", 128'(err_flag), 128'(1));
    cfg(32'h300, 32'h400, 16'd3);

    // Simultaneous cfg_load + request, unaligned base, num_blocks=0, address wrap
    xfer("cfg_rd", 1'b0, '0, {$urandom, $urandom, $urandom, $urandom}, 1, 1,
         1'b1, 32'hFFFF_FFF7, 32'hFFFF_FFEB, 16'd0, 1'b0);
    xfer("wrap_rd", 1'b0, '0, {$urandom, $urandom, $urandom, $urandom}, 4, 0,
         1'b0, '0, '0, '0, 1'b0);
    xfer("n0_wr", 1'b1, {$urandom, $urandom, $urandom, $urandom}, '0, 3, 3,
         1'b0, '0, '0, '0, 1'b0);

    // Randomized jobs
    for (int it = 0; it < 20; it++) begin
      rnd_tx = {$urandom, $urandom, $urandom, $urandom};
      rnd_rd = {$urandom, $urandom, $urandom, $urandom};
      rmode  = 1'($urandom_range(0, 1));
      rcfg   = ($urandom_range(0, 4) == 0);
      xfer($sformatf("rnd%0d", it), rmode, rnd_tx, rnd_rd, $urandom_range(0, 5),
           $urandom_range(1, 3), rcfg, $urandom, $urandom, 16'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
    end

    // Reset mid-burst, with an ignored request while busy
    ahb_shift_en = 1'b1; ahb_mode = 1'b1; tx_block = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1 ahb_shift_en = 1'b0;
    @(posedge clk); #1 ahb_shift_en = 1'b1;
    @(posedge clk); #1 ahb_shift_en = 1'b0;
    chk("rst/busy_before", 128'(busy), 128'(1));
    n_rst = 1'b0;
    #1 chk_reset("rst_mid");
    m_rd_ptr = '0; m_wr_ptr = '0; m_wr_cnt = '0; m_nblk = 16'd1;
    @(posedge clk); #1 n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("rst/no_done", 128'({blk_done, HTRANS}), 128'(0));
      @(posedge clk); #1;
    end
    xfer("post_rst_rd", 1'b0, '0, {$urandom, $urandom, $urandom, $urandom}, 0, 2,
         1'b0, '0, '0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
